// File: rtl/pipe_perf_monitor.sv
// Pipeline event monitor: cycle/stall/flush/retire counters, idle and cycle-budget done detection.
// Optional build macro PERF_SATURATE_EN: counters saturate and ovf_o flags the first would-be overflow.
module pipe_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLE  = 64,
    parameter int IDLE_LIMIT = 8
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic             clear_i,
    input  logic             freeze_i,
    input  logic [2:0]       sel_i,
    output logic [CNT_W-1:0] rdata_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // A budget wider than the cycle counter can never be reached, so it is treated as disabled.
    localparam logic [63:0]      MAX_CYCLE_W  = 64'(MAX_CYCLE);
    localparam bit               BUDGET_EN    = (MAX_CYCLE != 0) && ((MAX_CYCLE_W >> CNT_W) == 64'd0);
    localparam logic [CNT_W-1:0] MAX_CYCLE_C  = MAX_CYCLE_W[CNT_W-1:0];
    localparam logic [7:0]       IDLE_LIMIT_C = 8'(IDLE_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, cycle_nx;
    logic [CNT_W-1:0] stall_q, stall_d, stall_nx;
    logic [CNT_W-1:0] flush_q, flush_d, flush_nx;
    logic [CNT_W-1:0] retire_q, retire_d, retire_nx;
    logic [7:0]       idle_q, idle_d, idle_nx;
    logic             stall_inc;
    logic             done_hit;
    logic             counting;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
`ifdef PERF_SATURATE_EN
        return (en && !(&v)) ? v + CNT_W'(1) : v;
`else
        return en ? v + CNT_W'(1) : v;
`endif
    endfunction

    // A flush squashes whatever the stall was holding, so the overlap counts as a flush only.
    assign stall_inc = stall_i && !flush_i;
    assign cycle_nx  = bump(cycle_q, 1'b1);
    assign stall_nx  = bump(stall_q, stall_inc);
    assign flush_nx  = bump(flush_q, flush_i);
    assign retire_nx = bump(retire_q, retire_i);
    assign idle_nx   = retire_i ? 8'd0 : ((&idle_q) ? idle_q : idle_q + 8'd1);
    assign done_hit  = (BUDGET_EN && (cycle_nx == MAX_CYCLE_C)) || (idle_nx == IDLE_LIMIT_C);
    assign counting  = (state_q == ST_COUNT) && !clear_i && !freeze_i;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d  = state_q;
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        retire_d = retire_q;
        idle_d   = idle_q;
        if (clear_i) begin
            state_d  = ST_COUNT;
            cycle_d  = '0;
            stall_d  = '0;
            flush_d  = '0;
            retire_d = '0;
            idle_d   = '0;
        end else begin
            unique case (state_q)
                ST_COUNT: begin
                    if (freeze_i) begin
                        state_d = ST_HOLD;
                    end else begin
                        cycle_d  = cycle_nx;
                        stall_d  = stall_nx;
                        flush_d  = flush_nx;
                        retire_d = retire_nx;
                        idle_d   = idle_nx;
                        if (done_hit) state_d = ST_DONE;
                    end
                end
                ST_HOLD: if (!freeze_i) state_d = ST_COUNT;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_COUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: start_i is a synchronous reset, so it is sampled here rather than in the sensitivity list.
        if (!start_i) begin
            state_q  <= ST_COUNT;
            cycle_q  <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            retire_q <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            retire_q <= retire_d;
            idle_q   <= idle_d;
        end
    end

`ifdef PERF_SATURATE_EN
    logic ovf_q, ovf_d;
    logic any_ovf;

    assign any_ovf = (&cycle_q) | (stall_inc & (&stall_q)) | (flush_i & (&flush_q))
                   | (retire_i & (&retire_q));

    always_comb begin
        ovf_d = ovf_q;
        if (clear_i)                 ovf_d = 1'b0;
        else if (counting && any_ovf) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        unique case (sel_i)
            3'd0:    rdata_o = cycle_q;
            3'd1:    rdata_o = stall_q;
            3'd2:    rdata_o = flush_q;
            3'd3:    rdata_o = retire_q;
            3'd4:    rdata_o = CNT_W'({state_q, idle_q});
            default: rdata_o = '0;
        endcase
    end

    assign cycle_o      = cycle_q;
    assign stall_cnt_o  = stall_q;
    assign flush_cnt_o  = flush_q;
    assign retire_cnt_o = retire_q;
    assign state_o      = state_q;
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a default instance plus a 4-bit-counter instance for wrap/saturate.
module tb_pipe_perf_monitor;

    logic        clk_i = 1'b0;
    logic        start_i, stall_i, flush_i, retire_i, clear_i, freeze_i;
    logic [2:0]  sel_i;

    logic [31:0] a_rdata, a_cycle, a_stall, a_flush, a_retire;
    logic [1:0]  a_state;
    logic        a_done, a_ovf;
    logic [3:0]  b_rdata, b_cycle, b_stall, b_flush, b_retire;
    logic [1:0]  b_state;
    logic        b_done, b_ovf;

    int n_vec = 0;
    int n_err = 0;

`ifdef PERF_SATURATE_EN
    localparam logic [3:0] EXP_WRAP  = 4'd15;
    localparam logic       EXP_OVF16 = 1'b1;
`else
    localparam logic [3:0] EXP_WRAP  = 4'd4;
    localparam logic       EXP_OVF16 = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLE(64), .IDLE_LIMIT(8)) u_dut_a (
        .clk_i(clk_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
        .retire_i(retire_i), .clear_i(clear_i), .freeze_i(freeze_i), .sel_i(sel_i),
        .rdata_o(a_rdata), .cycle_o(a_cycle), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush),
        .retire_cnt_o(a_retire), .state_o(a_state), .done_o(a_done), .ovf_o(a_ovf)
    );

    pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLE(0), .IDLE_LIMIT(8)) u_dut_b (
        .clk_i(clk_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
        .retire_i(retire_i), .clear_i(clear_i), .freeze_i(freeze_i), .sel_i(sel_i),
        .rdata_o(b_rdata), .cycle_o(b_cycle), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush),
        .retire_cnt_o(b_retire), .state_o(b_state), .done_o(b_done), .ovf_o(b_ovf)
    );

    // Drive one cycle of inputs, take the edge, then settle before sampling.
    task automatic step(input logic st, input logic fl, input logic rt, input logic cl, input logic fr);
        stall_i  = st;
        flush_i  = fl;
        retire_i = rt;
        clear_i  = cl;
        freeze_i = fr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [127:0] got;
        start_i = 1'b0;
        sel_i   = 3'd0;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        got = {a_cycle, a_stall, a_flush, a_retire};
        n_vec++; if (got !== 128'd0) begin n_err++; $display("FAIL reset_counters got=%h exp=0", got); end
        n_vec++; if (a_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", a_state); end
        n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", a_done); end
        n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", a_ovf); end
        n_vec++; if (a_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got=%0d exp=0", a_rdata); end
        n_vec++; if ({b_cycle, b_stall, b_flush, b_retire} !== 16'd0) begin
            n_err++; $display("FAIL reset_b_counters got=%h exp=0", {b_cycle, b_stall, b_flush, b_retire});
        end
    endtask

    task automatic test_counting();
        logic [2:0]   vec [10];
        logic [127:0] got;
        vec = '{3'b101, 3'b101, 3'b111, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        start_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(vec[i][2], vec[i][1], vec[i][0], 1'b0, 1'b0);
            if (i == 2) begin
                got = {a_cycle, a_stall, a_flush, a_retire};
                n_vec++; if (got !== {32'd3, 32'd2, 32'd1, 32'd3}) begin
                    n_err++; $display("FAIL count_mid got=%h exp=%h", got, {32'd3, 32'd2, 32'd1, 32'd3});
                end
            end
        end
        got = {a_cycle, a_stall, a_flush, a_retire};
        n_vec++; if (got !== {32'd10, 32'd2, 32'd2, 32'd5}) begin
            n_err++; $display("FAIL count_end got=%h exp=%h", got, {32'd10, 32'd2, 32'd2, 32'd5});
        end
        sel_i = 3'd4;
        #1;
        n_vec++; if (a_rdata !== 32'd5) begin n_err++; $display("FAIL count_idle_rd got=%0d exp=5", a_rdata); end
        sel_i = 3'd0;
    endtask

    task automatic test_freeze();
        logic [127:0] got;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            got = {a_cycle, a_stall, a_flush, a_retire};
            n_vec++; if (a_state !== 2'd1) begin n_err++; $display("FAIL freeze_state[%0d] got=%0d exp=1", i, a_state); end
            n_vec++; if (got !== {32'd10, 32'd2, 32'd2, 32'd5}) begin
                n_err++; $display("FAIL freeze_hold[%0d] got=%h", i, got);
            end
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        got = {a_cycle, a_stall, a_flush, a_retire};
        n_vec++; if (a_state !== 2'd0) begin n_err++; $display("FAIL release_state got=%0d exp=0", a_state); end
        n_vec++; if (got !== {32'd10, 32'd2, 32'd2, 32'd5}) begin n_err++; $display("FAIL release_hold got=%h", got); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        got = {a_cycle, a_stall, a_flush, a_retire};
        n_vec++; if (got !== {32'd11, 32'd3, 32'd2, 32'd6}) begin
            n_err++; $display("FAIL resume_count got=%h exp=%h", got, {32'd11, 32'd3, 32'd2, 32'd6});
        end
    endtask

    task automatic test_idle_done();
        logic [127:0] got;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        got = {a_cycle, a_stall, a_flush, a_retire};
        n_vec++; if (got !== 128'd0) begin n_err++; $display("FAIL clear_counters got=%h exp=0", got); end
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 7) begin
                n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL idle7_done got=%b exp=0", a_done); end
            end
        end
        got = {a_cycle, a_stall, a_flush, a_retire};
        n_vec++; if (a_done !== 1'b1) begin n_err++; $display("FAIL idle8_done got=%b exp=1", a_done); end
        n_vec++; if (a_state !== 2'd2) begin n_err++; $display("FAIL idle8_state got=%0d exp=2", a_state); end
        n_vec++; if (got !== {32'd8, 32'd8, 32'd0, 32'd0}) begin n_err++; $display("FAIL idle8_counters got=%h", got); end
        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        got = {a_cycle, a_stall, a_flush, a_retire};
        n_vec++; if (got !== {32'd8, 32'd8, 32'd0, 32'd0}) begin n_err++; $display("FAIL done_hold got=%h", got); end
        n_vec++; if (a_done !== 1'b1) begin n_err++; $display("FAIL done_sticky got=%b exp=1", a_done); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        got = {a_cycle, a_stall, a_flush, a_retire};
        sel_i = 3'd4;
        #1;
        n_vec++; if (got !== 128'd0) begin n_err++; $display("FAIL done_clear got=%h exp=0", got); end
        n_vec++; if ({a_state, a_done} !== 3'b000) begin
            n_err++; $display("FAIL done_clear_state got=%0d/%b exp=0/0", a_state, a_done);
        end
        n_vec++; if (a_rdata !== 32'd0) begin n_err++; $display("FAIL done_clear_rd got=%0d exp=0", a_rdata); end
        sel_i = 3'd0;
    endtask

    task automatic test_budget();
        logic [31:0] exp_rd [8];
        exp_rd = '{32'd64, 32'd0, 32'd0, 32'd32, 32'h201, 32'd0, 32'd0, 32'd0};
        for (int i = 1; i <= 64; i++) begin
            step(1'b0, 1'b0, logic'(i % 2), 1'b0, 1'b0);
            if (i == 63) begin
                n_vec++; if ({a_cycle, 1'b0, a_done} !== {32'd63, 1'b0, 1'b0}) begin
                    n_err++; $display("FAIL budget63 got=%0d/%b exp=63/0", a_cycle, a_done);
                end
            end
        end
        n_vec++; if ({a_cycle, 1'b0, a_done} !== {32'd64, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL budget64 got=%0d/%b exp=64/1", a_cycle, a_done);
        end
        for (int s = 0; s < 8; s++) begin
            sel_i = 3'(s);
            #1;
            n_vec++; if (a_rdata !== exp_rd[s]) begin
                n_err++; $display("FAIL readback sel=%0d got=%h exp=%h", s, a_rdata, exp_rd[s]);
            end
        end
        sel_i = 3'd0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++; if (a_cycle !== 32'd64) begin n_err++; $display("FAIL budget_hold got=%0d exp=64", a_cycle); end
    endtask

    task automatic test_wrap();
        start_i = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 15) begin
                n_vec++; if ({b_stall, b_ovf} !== {4'd15, 1'b0}) begin
                    n_err++; $display("FAIL wrap15 got=%0d/%b exp=15/0", b_stall, b_ovf);
                end
            end
            if (i == 16) begin
                n_vec++; if (b_ovf !== EXP_OVF16) begin
                    n_err++; $display("FAIL wrap16_ovf got=%b exp=%b", b_ovf, EXP_OVF16);
                end
            end
        end
        n_vec++; if ({b_cycle, b_stall, b_retire} !== {EXP_WRAP, EXP_WRAP, EXP_WRAP}) begin
            n_err++; $display("FAIL wrap20 got=%h exp=%h", {b_cycle, b_stall, b_retire}, {EXP_WRAP, EXP_WRAP, EXP_WRAP});
        end
        n_vec++; if (b_ovf !== EXP_OVF16) begin n_err++; $display("FAIL wrap20_ovf got=%b exp=%b", b_ovf, EXP_OVF16); end
        n_vec++; if ({b_state, b_done} !== 3'b000) begin
            n_err++; $display("FAIL wrap_state got=%0d/%b exp=0/0", b_state, b_done);
        end
        n_vec++; if ({a_cycle, a_ovf} !== {32'd20, 1'b0}) begin
            n_err++; $display("FAIL wrap_a got=%0d/%b exp=20/0", a_cycle, a_ovf);
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_vec++; if ({b_stall, b_ovf} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL wrap_clear got=%0d/%b exp=0/0", b_stall, b_ovf);
        end
    endtask

    initial begin
        start_i  = 1'b0;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        retire_i = 1'b0;
        clear_i  = 1'b0;
        freeze_i = 1'b0;
        sel_i    = 3'd0;
        #2;
        test_reset();
        test_counting();
        test_freeze();
        test_idle_done();
        test_budget();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
